aes_key_sched_ctrl: RTL and testbench

Sequential AES-128 key-schedule controller that replaces the fully unrolled combinational expansion with one round-key step per clock. On a start strobe it captures a 128-bit cipher key, generates round keys 0..10 over 11 cycles, and stores them in an internal 11×128 register file. The register file is read by the encryption round sequencer through a registered random-access port. Each key is also streamed once as it is produced, for pipelined consumers.

---
 rtl/aes_key_sched_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequential AES-128 key schedule, one round key per clock.
// A start strobe in idle captures key_in_i. Round keys 0..10 are written to an internal
// 11 x 128 register file over 11 cycles, and each one is streamed once, a cycle after it
// is written.
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i, key_in_i expansion request (sampled only in idle) and cipher key
//   busy_o            expansion in progress
//   done_o            one-cycle pulse after round key 10 is written
//   key_valid_o       all 11 round keys stored and stable
//   rk_valid_o/rk_idx_o/rk_data_o  streaming beat of each round key as it is written
//   rd_addr_i/rd_data_o            registered random-access read (0 for addr > 10)

// 8-bit AES forward S-box as a constant lookup table.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Entry 0 sits in the top byte, so entry x lives at bit offset (255 - x) * 8.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SboxTable[{~data_i, 3'b000} +: 8];

endmodule

module aes_key_sched_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_in_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         key_valid_o,
  output logic         rk_valid_o,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_data_o,
  input  logic [3:0]   rd_addr_i,
  output logic [127:0] rd_data_o
);

  if (NR != 10) begin : gen_bad_nr
    $error("aes_key_sched_ctrl: only NR = 10 (AES-128) is supported");
  end

  localparam int unsigned NumKeys = 11;
  localparam logic [3:0]  LastIdx = 4'd10;

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] w_q, w_d;
  logic [127:0] rk_q [NumKeys];
  logic         done_q, done_d;
  logic         kv_q, kv_d;
  logic         rkv_q, rkv_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic [127:0] rk_data_q, rk_data_d;
  logic [127:0] rd_data_q, rd_data_d;

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;

  // One round of the word recurrence on the working words {w0, w1, w2, w3}.
  logic [31:0] rot_w, sub_w, g_w, n0, n1, n2, n3;
  logic [7:0]  rcon_next;

  assign rot_w = {w_q[23:0], w_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : gen_subword
    aes_sbox u_sbox (
      .data_i (rot_w[8*i +: 8]),
      .data_o (sub_w[8*i +: 8])
    );
  end

  assign g_w       = sub_w ^ {rcon_q, 24'h0};
  assign n0        = w_q[127:96] ^ g_w;
  assign n1        = w_q[95:64] ^ n0;
  assign n2        = w_q[63:32] ^ n1;
  assign n3        = w_q[31:0] ^ n2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = {n0, n1, n2, n3};
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StExpand;
          idx_d   = 4'd1;
          rcon_d  = 8'h01;
          w_d     = key_in_i;
          kv_d    = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = key_in_i;
        end
      end
      StExpand: begin
        wr_en  = 1'b1;
        w_d    = {n0, n1, n2, n3};
        rcon_d = rcon_next;
        idx_d  = idx_q + 4'd1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Every register-file write is echoed as a streaming beat one cycle later.
  always_comb begin
    rkv_d     = wr_en;
    rk_idx_d  = wr_en ? wr_idx : rk_idx_q;
    rk_data_d = wr_en ? wr_data : rk_data_q;
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NumKeys; i++) begin
      if (rd_addr_i == 4'(i)) rd_data_d = rk_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rcon_q    <= '0;
      w_q       <= '0;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
      rkv_q     <= 1'b0;
      rk_idx_q  <= '0;
      rk_data_q <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NumKeys; i++) rk_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rcon_q    <= rcon_d;
      w_q       <= w_d;
      done_q    <= done_d;
      kv_q      <= kv_d;
      rkv_q     <= rkv_d;
      rk_idx_q  <= rk_idx_d;
      rk_data_q <= rk_data_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NumKeys; i++) begin
        if (wr_en && wr_idx == 4'(i)) rk_q[i] <= wr_data;
      end
    end
  end

  assign busy_o      = (state_q == StExpand);
  assign done_o      = done_q;
  assign key_valid_o = kv_q;
  assign rk_valid_o  = rkv_q;
  assign rk_idx_o    = rk_idx_q;
  assign rk_data_o   = rk_data_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: a reference key expansion built from GF(2^8) arithmetic
// (S-box derived from field inverses), a monitor that records every streaming beat and
// done pulse with its cycle number, and one task per scenario.
module tb_aes_key_sched_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [127:0] key_in_i;
  logic         busy_o, done_o, key_valid_o, rk_valid_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_data_o;
  logic [3:0]   rd_addr_i;
  logic [127:0] rd_data_o;

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .key_in_i    (key_in_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .key_valid_o (key_valid_o),
    .rk_valid_o  (rk_valid_o),
    .rk_idx_o    (rk_idx_o),
    .rk_data_o   (rk_data_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] r, s;
      for (int v = 1; v < 256; v++) if (gmul(8'(x), 8'(v)) == 8'h01) inv = 8'(v);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_tab[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [10:0][127:0] expand_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [10:0][127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // ---------------- monitor ----------------
  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    int           cyc;
  } beat_t;

  beat_t beats[$];
  int    dones[$];
  int    cyc = 0;
  int    prev_idx = -1;
  int    gaps = 0;

  always begin
    beat_t b;
    @(posedge clk_i);
    #1;
    cyc++;
    if (rk_valid_o === 1'b1) begin
      b.idx  = rk_idx_o;
      b.data = rk_data_o;
      b.cyc  = cyc;
      if (rk_idx_o != 4'd0 && int'(rk_idx_o) != prev_idx + 1) gaps++;
      prev_idx = int'(rk_idx_o);
      beats.push_back(b);
    end
    if (done_o === 1'b1) dones.push_back(cyc);
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_log();
    beats.delete();
    dones.delete();
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One-cycle start pulse; returns the monitor cycle number of the capture edge.
  task automatic do_start(input logic [127:0] key, output int cap);
    key_in_i = key;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    cap      = cyc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i     = 1'b1;
    start_i   = 1'b0;
    key_in_i  = '0;
    rd_addr_i = 4'd0;
    repeat (3) step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL reset_kv got %b want 0", key_valid_o); end
    checks++; if (rk_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rkv got %b want 0", rk_valid_o); end
    checks++; if (rk_idx_o !== 4'd0) begin errors++; $display("FAIL reset_rkidx got %h want 0", rk_idx_o); end
    checks++; if (rk_data_o !== 128'd0) begin errors++; $display("FAIL reset_rkdata got %h want 0", rk_data_o); end
    checks++; if (rd_data_o !== 128'd0) begin errors++; $display("FAIL reset_rddata got %h want 0", rd_data_o); end
    rst_i = 1'b0;
    repeat (2) step();
    checks++; if (rk_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset rkv=%b busy=%b want 0 0", rk_valid_o, busy_o);
    end
  endtask

  task automatic test_fips();
    logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [10:0][127:0] rf = expand_ref(key);
    int cap;
    clear_log();
    do_start(key, cap);
    for (int j = 1; j <= 11; j++) begin
      checks++; if (busy_o !== (j <= 10)) begin
        errors++; $display("FAIL fips_busy T0+%0d got %b want %b", j, busy_o, j <= 10);
      end
      checks++; if (key_valid_o !== (j == 11) || done_o !== (j == 11)) begin
        errors++; $display("FAIL fips_kv_done T0+%0d got kv=%b done=%b want %b", j, key_valid_o,
                           done_o, j == 11);
      end
      step();
    end
    checks++; if (beats.size() != 11) begin
      errors++; $display("FAIL fips_beat_count got %0d want 11", beats.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++; if (beats[i].idx !== 4'(i) || beats[i].data !== rf[i] || beats[i].cyc != cap + i)
        begin
          errors++; $display("FAIL fips_beat%0d got idx=%0d data=%h cyc=%0d want %0d %h %0d", i,
                             beats[i].idx, beats[i].data, beats[i].cyc, i, rf[i], cap + i);
        end
      end
      checks++; if (beats[0].data !== key) begin
        errors++; $display("FAIL fips_beat0_const got %h want %h", beats[0].data, key);
      end
      checks++; if (beats[1].data !== 128'ha0fafe1788542cb123a339392a6c7605) begin
        errors++; $display("FAIL fips_beat1_const got %h want a0fafe17...", beats[1].data);
      end
      checks++; if (beats[10].data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
        errors++; $display("FAIL fips_beat10_const got %h want d014f9a8...", beats[10].data);
      end
    end
    checks++; if (dones.size() != 1 || dones[0] != cap + 10) begin
      errors++; $display("FAIL fips_done count=%0d cyc=%0d want 1 at %0d", dones.size(),
                         (dones.size() > 0) ? dones[0] : -1, cap + 10);
    end
  endtask

  task automatic test_zero_readback();
    logic [10:0][127:0] rf = expand_ref(128'd0);
    int cap;
    clear_log();
    do_start(128'd0, cap);
    repeat (12) step();
    for (int a = 0; a < 16; a++) begin
      logic [127:0] exp_v = (a <= 10) ? rf[a] : 128'd0;
      rd_addr_i = 4'(a);
      step();
      checks++; if (rd_data_o !== exp_v) begin
        errors++; $display("FAIL zero_read addr=%0d got %h want %h", a, rd_data_o, exp_v);
      end
    end
    rd_addr_i = 4'd1;
    step();
    checks++; if (rd_data_o !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_rk1_const got %h want 62636363...", rd_data_o);
    end
    rd_addr_i = 4'd10;
    step();
    checks++; if (rd_data_o !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++; $display("FAIL zero_rk10_const got %h want b4ef5bcb...", rd_data_o);
    end
  endtask

  task automatic test_start_held();
    logic [127:0] key = rand_key();
    logic [10:0][127:0] rf = expand_ref(key);
    int cap;
    clear_log();
    key_in_i = key;
    start_i  = 1'b1;
    step();
    cap = cyc;
    for (int k = 0; k < 4; k++) begin
      key_in_i = rand_key();
      step();
    end
    start_i = 1'b0;
    repeat (2) step();
    key_in_i = rand_key();
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    repeat (8) step();
    checks++; if (beats.size() != 11) begin
      errors++; $display("FAIL held_beat_count got %0d want 11", beats.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++; if (beats[i].idx !== 4'(i) || beats[i].data !== rf[i]) begin
          errors++; $display("FAIL held_beat%0d got idx=%0d data=%h want %0d %h", i,
                             beats[i].idx, beats[i].data, i, rf[i]);
        end
      end
    end
    checks++; if (dones.size() != 1 || dones[0] != cap + 10) begin
      errors++; $display("FAIL held_done count=%0d want exactly 1 at %0d", dones.size(), cap + 10);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka = rand_key();
    logic [127:0] kb = rand_key();
    logic [10:0][127:0] ra = expand_ref(ka);
    logic [10:0][127:0] rb = expand_ref(kb);
    int cap, cap2;
    clear_log();
    do_start(ka, cap);
    repeat (9) step();
    checks++; if (key_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_kv_T0+10 got %b want 0", key_valid_o);
    end
    step();
    checks++; if (key_valid_o !== 1'b1 || done_o !== 1'b1) begin
      errors++; $display("FAIL b2b_kv_T0+11 got kv=%b done=%b want 1 1", key_valid_o, done_o);
    end
    do_start(kb, cap2);
    checks++; if (key_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL b2b_T0+12 got kv=%b busy=%b want 0 1", key_valid_o, busy_o);
    end
    checks++; if (beats.size() != 12 || beats[11].idx !== 4'd0 || beats[11].data !== kb ||
                  beats[11].cyc != cap + 11) begin
      errors++; $display("FAIL b2b_new_beat0 count=%0d want 12 with idx 0 data %h at %0d",
                         beats.size(), kb, cap + 11);
    end
    repeat (11) step();
    checks++; if (beats.size() != 22) begin
      errors++; $display("FAIL b2b_beat_count got %0d want 22", beats.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++; if (beats[i].data !== ra[i] || beats[11+i].data !== rb[i]) begin
          errors++; $display("FAIL b2b_beat%0d got %h/%h want %h/%h", i, beats[i].data,
                             beats[11+i].data, ra[i], rb[i]);
        end
      end
    end
    rd_addr_i = 4'd10;
    step();
    checks++; if (rd_data_o !== rb[10]) begin
      errors++; $display("FAIL b2b_rk10 got %h want %h", rd_data_o, rb[10]);
    end
    checks++; if (dones.size() != 2) begin
      errors++; $display("FAIL b2b_done_count got %0d want 2", dones.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ka = rand_key();
    logic [127:0] kb = rand_key();
    logic [10:0][127:0] rb = expand_ref(kb);
    int cap;
    clear_log();
    do_start(ka, cap);
    repeat (4) step();
    #3;
    rst_i = 1'b1;
    #1;
    checks++; if ({busy_o, done_o, key_valid_o, rk_valid_o} !== 4'b0 || rk_idx_o !== 4'd0 ||
                  rk_data_o !== 128'd0 || rd_data_o !== 128'd0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b done=%b kv=%b rkv=%b idx=%h data=%h rd=%h want all 0",
                         busy_o, done_o, key_valid_o, rk_valid_o, rk_idx_o, rk_data_o, rd_data_o);
    end
    repeat (2) step();
    rst_i = 1'b0;
    clear_log();
    repeat (15) step();
    checks++; if (dones.size() != 0 || beats.size() != 0) begin
      errors++; $display("FAIL midrst_quiet got dones=%0d beats=%0d want 0 0", dones.size(),
                         beats.size());
    end
    do_start(kb, cap);
    repeat (11) step();
    checks++; if (beats.size() != 11) begin
      errors++; $display("FAIL midrst_beat_count got %0d want 11", beats.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++; if (beats[i].idx !== 4'(i) || beats[i].data !== rb[i]) begin
          errors++; $display("FAIL midrst_beat%0d got %h want %h", i, beats[i].data, rb[i]);
        end
      end
    end
    checks++; if (dones.size() != 1) begin
      errors++; $display("FAIL midrst_done_count got %0d want 1", dones.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      logic [127:0] key = rand_key();
      logic [10:0][127:0] rf = expand_ref(key);
      int cap;
      clear_log();
      do_start(key, cap);
      repeat (11) step();
      checks++; if (beats.size() != 11) begin
        errors++; $display("FAIL rand%0d_beat_count got %0d want 11", n, beats.size());
      end else begin
        for (int i = 0; i < 11; i++) begin
          checks++; if (beats[i].data !== rf[i]) begin
            errors++; $display("FAIL rand%0d_beat%0d got %h want %h", n, i, beats[i].data, rf[i]);
          end
        end
      end
      for (int r = 0; r < 6; r++) begin
        int a = $urandom_range(0, 15);
        logic [127:0] exp_v = (a <= 10) ? rf[a] : 128'd0;
        rd_addr_i = 4'(a);
        step();
        checks++; if (rd_data_o !== exp_v) begin
          errors++; $display("FAIL rand%0d_read addr=%0d got %h want %h", n, a, rd_data_o, exp_v);
        end
      end
    end
  endtask

  task automatic test_streaming();
    clear_log();
    repeat (5) step();
    checks++; if (beats.size() != 0) begin
      errors++; $display("FAIL stream_idle_beats got %0d want 0", beats.size());
    end
    checks++; if (gaps != 0) begin
      errors++; $display("FAIL stream_gaps got %0d want 0", gaps);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_zero_readback();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
